mem_port_arbiter: RTL

- Arbitrates a single-port, byte-addressed unified memory (instruction + data) between the core's instruction-fetch requester and its load/store requester.
- Issues one access per cycle with fixed data priority and a bounded-starvation guarantee for fetch.
- Routes the 1-cycle-latency read data back to the requester that was granted.
- Sits between the riscv core pipeline and mem1.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, byte-addressed unified memory
// between instruction fetch and load/store. Data has fixed priority, and
// fetch is protected from starvation by a saturating denial counter.
// Read data has a 1-cycle latency and is steered back to the requester
// whose read was granted.
// Optional build macro: MEM_ARB_STATS_EN adds the stat_conflict and
// stat_if_stall event counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store requester
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_conflict,
  output logic [31:0]       stat_if_stall
`endif
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_DM   = 2'd2
  } rsp_t;

  rsp_t       resp_owner_r;
  rsp_t       resp_owner_next_s;
  logic [3:0] starve_cnt_r;
  logic       starved_s;

  assign starved_s = (starve_cnt_r == STARVE_MAX_C);

  // Grant decision: data first, fetch wins once it has been denied STARVE_MAX times.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (dm_req && !(if_req && starved_s)) begin
      dm_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end else begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  // Memory port drive: mirror the granted requester, quiet when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_we   = 1'b0;
      mem_be   = 4'hF;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      // loads always read the whole word; a store with no enables writes nothing
      mem_be    = dm_we ? dm_be : 4'hF;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Fetch starvation counter: counts consecutive denied fetch cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (if_req && !if_gnt) begin
      if (!starved_s) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

  // Response owner state register: remembers whose read is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner_r <= RSP_NONE;
    end else begin
      resp_owner_r <= resp_owner_next_s;
    end
  end

  // Response owner next state: follows this cycle's grant, stores and idle go to none.
  always_comb begin
    resp_owner_next_s = RSP_NONE;
    case ({if_gnt, dm_gnt})
      2'b10:   resp_owner_next_s = RSP_IF;
      2'b01:   resp_owner_next_s = dm_we ? RSP_NONE : RSP_DM;
      default: resp_owner_next_s = RSP_NONE;
    endcase
  end

  // Read data return: valid decodes straight from the state register.
  assign if_rvalid = (resp_owner_r == RSP_IF);
  assign dm_rvalid = (resp_owner_r == RSP_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  // Event counters: request conflicts and stalled fetch cycles, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflict <= 32'd0;
      stat_if_stall <= 32'd0;
    end else begin
      if (if_req && dm_req) begin
        stat_conflict <= stat_conflict + 32'd1;
      end else begin
        stat_conflict <= stat_conflict;
      end
      if (if_req && !if_gnt) begin
        stat_if_stall <= stat_if_stall + 32'd1;
      end else begin
        stat_if_stall <= stat_if_stall;
      end
    end
  end
`endif

endmodule
